// File: rtl/spi_load_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_load_pkg
// Purpose : Shared state encoding, error codes and SPI addressing constants.
// Rev     : 1.0
// ============================================================================
package spi_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LRST   = 3'd2,
    ST_EN_QPI = 3'd3,
    ST_LOAD   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] c_err_bad_cmd = 2'd0;
  localparam logic [1:0] c_err_abort   = 2'd1;
  localparam logic [1:0] c_err_count   = 2'd2;
  localparam logic [1:0] c_err_timeout = 2'd3;

  localparam logic [31:0] SPI_ADDR_SEG1 = 32'h0010_0000;
  localparam logic [31:0] NO_SPLIT      = 32'hFFFF_FFFF;

  // A segment covering zero or all words means the loader never re-addresses.
  function automatic logic [31:0] split_index(input logic [31:0] instr_words,
                                              input logic [31:0] seg0_words);
    if (seg0_words == 32'd0 || seg0_words == instr_words)
      return NO_SPLIT;
    return seg0_words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_load_wdt.sv
`default_nettype none
// ============================================================================
// Module  : spi_load_wdt
// Purpose : Phase watchdog counter with synchronous clear, enable and expire.
// Rev     : 1.0
// ============================================================================
module spi_load_wdt #(
  parameter int unsigned CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int          c_w    = $clog2(CYCLES) + 1;
  localparam logic [c_w-1:0] c_last = c_w'(CYCLES - 1);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != c_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en & ~i_clr & (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/spi_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : spi_load_sequencer
// Purpose : Sequences one program-load job through the negedge SPI loader.
//           Optional phase watchdog enabled by defining SPI_LOAD_WDT_EN.
// Rev     : 1.0
// ============================================================================
module spi_load_sequencer #(
  parameter int unsigned LDR_RST_CYC = 4,
  parameter int unsigned WDT_CYCLES  = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr_words,
  input  logic [31:0] cmd_seg0_words,
  input  logic        cmd_use_qspi,
  input  logic        cmd_abort,
  output logic        loader_rst_n,
  output logic        start_spi,
  output logic        start_load,
  output logic [31:0] spi_addr_idx,
  output logic [31:0] instr_num,
  output logic        use_qspi,
  input  logic        ldr_setup_i,
  input  logic        rb_valid_i,
  input  logic        rb_ready_i,
  input  logic        fetch_en_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] words_sent
);

  import spi_load_pkg::*;

  localparam logic [31:0] c_rst_last = 32'(LDR_RST_CYC - 1);

  state_t      r_state;
  logic        r_rdy;
  logic [31:0] r_instr_words;
  logic [31:0] r_seg0_words;
  logic        r_qspi;
  logic [31:0] r_rst_cnt;

  logic w_accept;
  logic w_beat;
  logic w_active;
  logic w_kill;
  logic w_wdt_expired;

  assign cmd_ready = r_rdy & ~cmd_abort & (r_state == ST_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_beat    = rb_valid_i & rb_ready_i;
  assign w_active  = (r_state == ST_CHECK) || (r_state == ST_LRST) ||
                     (r_state == ST_EN_QPI) || (r_state == ST_LOAD);
  assign w_kill    = w_active & (cmd_abort | w_wdt_expired);

`ifdef SPI_LOAD_WDT_EN
  logic w_wdt_clr;
  logic w_wdt_en;

  assign w_wdt_clr = ((r_state == ST_LRST) && (r_rst_cnt == c_rst_last)) ||
                     ((r_state == ST_EN_QPI) && ldr_setup_i) ||
                     ((r_state == ST_LOAD) && w_beat);
  assign w_wdt_en  = (r_state == ST_EN_QPI) || (r_state == ST_LOAD);

  spi_load_wdt #(
    .CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_wdt_clr),
    .i_en      (w_wdt_en),
    .o_expired (w_wdt_expired)
  );
`else
  logic [31:0] w_unused_wdt_cfg;
  assign w_unused_wdt_cfg = WDT_CYCLES;
  assign w_wdt_expired    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rdy         <= 1'b0;
      r_instr_words <= '0;
      r_seg0_words  <= '0;
      r_qspi        <= 1'b0;
      r_rst_cnt     <= '0;
      loader_rst_n  <= 1'b0;
      start_spi     <= 1'b0;
      start_load    <= 1'b0;
      spi_addr_idx  <= '0;
      instr_num     <= '0;
      use_qspi      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= c_err_bad_cmd;
      words_sent    <= '0;
    end else if (w_kill) begin
      // Abort outranks every normal transition; the loader is held in reset.
      loader_rst_n <= 1'b0;
      start_spi    <= 1'b0;
      start_load   <= 1'b0;
      error        <= 1'b1;
      err_code     <= cmd_abort ? c_err_abort : c_err_timeout;
      busy         <= 1'b0;
      r_state      <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_instr_words <= cmd_instr_words;
            r_seg0_words  <= cmd_seg0_words;
            r_qspi        <= cmd_use_qspi;
            done          <= 1'b0;
            error         <= 1'b0;
            words_sent    <= '0;
            busy          <= 1'b1;
            r_rdy         <= 1'b0;
            r_state       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_instr_words == 32'd0 || r_seg0_words > r_instr_words) begin
            error    <= 1'b1;
            err_code <= c_err_bad_cmd;
            busy     <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            instr_num    <= r_instr_words + 32'd1;
            spi_addr_idx <= split_index(r_instr_words, r_seg0_words);
            use_qspi     <= r_qspi;
            loader_rst_n <= 1'b0;
            r_rst_cnt    <= '0;
            r_state      <= ST_LRST;
          end
        end
        ST_LRST: begin
          if (r_rst_cnt == c_rst_last) begin
            loader_rst_n <= 1'b1;
            r_state      <= ST_EN_QPI;
          end else begin
            r_rst_cnt <= r_rst_cnt + 32'd1;
          end
        end
        ST_EN_QPI: begin
          start_spi <= 1'b1;
          if (ldr_setup_i) begin
            start_load <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_beat && words_sent != 32'hFFFF_FFFF)
            words_sent <= words_sent + 32'd1;
          if (fetch_en_i)
            r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          // loader_rst_n stays high so the loader keeps fetch_enable asserted.
          if (words_sent == r_instr_words) begin
            done <= 1'b1;
          end else begin
            error    <= 1'b1;
            err_code <= c_err_count;
          end
          start_spi  <= 1'b0;
          start_load <= 1'b0;
          busy       <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
